uart_rx_frame: RTL and testbench

Parametrised UART receiver for the SDAD host link: the successor to the fixed 8-bit single-stop receiver. It has configurable data width, optional odd/even parity and one or two stop bits. Each received frame is delivered on a ready/read handshake, with per-frame framing and parity flags and a sticky overrun flag. It sits between the board serial input pin and the command decoder that configures the sigma-delta chain.

---
 rtl/uart_rx_frame.sv | 209 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - parametrised UART receiver with parity, stop-bit checks and read handshake
module uart_rx_frame #(
    parameter int C_CLK_FRQ   = 100000000,
    parameter int C_TRX_RATE  = 1000000,
    parameter int C_DATA_BITS = 8,
    parameter int C_PARITY    = 0,
    parameter int C_STOP_BITS = 1
) (
    input  logic                   clk,
    input  logic                   rstb,
    input  logic                   rx,
    input  logic                   read,
    output logic [C_DATA_BITS-1:0] data,
    output logic                   ready,
    output logic                   err_frame,
    output logic                   err_parity,
    output logic                   err_overrun,
    output logic                   busy
);

    localparam int P  = C_CLK_FRQ / C_TRX_RATE;
    localparam int H  = P / 2;
    localparam int CW = $clog2(P + 1);

    localparam logic [CW-1:0] C_P_LAST  = CW'(P - 1);
    localparam logic [CW-1:0] C_H_LAST  = CW'(H - 1);
    localparam logic [3:0]    C_DB_LAST = 4'(C_DATA_BITS - 1);
    localparam logic [3:0]    C_SB_LAST = 4'(C_STOP_BITS - 1);
    localparam logic          C_PAR_REF = (C_PARITY == 1);

    generate
        if (P < 4) begin : g_bad_rate
            $error("uart_rx_frame: C_CLK_FRQ/C_TRX_RATE must be at least 4");
        end
        if (C_DATA_BITS < 5 || C_DATA_BITS > 9) begin : g_bad_width
            $error("uart_rx_frame: C_DATA_BITS must be 5..9");
        end
        if (C_PARITY < 0 || C_PARITY > 2) begin : g_bad_parity
            $error("uart_rx_frame: C_PARITY must be 0, 1 or 2");
        end
        if (C_STOP_BITS < 1 || C_STOP_BITS > 2) begin : g_bad_stop
            $error("uart_rx_frame: C_STOP_BITS must be 1 or 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } t_state;

    t_state                   r_state;
    t_state                   w_state_nxt;
    logic                     r_rx_m;
    logic                     r_rx_s;
    logic [CW-1:0]            r_cnt;
    logic [3:0]               r_nb;
    logic [C_DATA_BITS-1:0]   r_shift;
    logic                     r_armed;
    logic                     r_ferr;
    logic                     r_perr;
    logic                     r_commit;
    logic                     r_busy;
    logic [C_DATA_BITS-1:0]   r_data;
    logic                     r_ready;
    logic                     r_err_frame;
    logic                     r_err_parity;
    logic                     r_err_overrun;

    logic                     w_sample;
    logic                     w_last_bit;
    logic                     w_frame_end;
    logic                     w_ferr_final;
    logic                     w_state_chg;
    logic                     w_start_entry;

    // rx is asynchronous to clk; reset to the idle level so reset never looks like a start bit
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != S_IDLE);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (r_armed && !r_rx_s) w_state_nxt = S_START;
            S_START:  if (w_sample) w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
            S_DATA:   if (w_sample && w_last_bit)
                          w_state_nxt = (C_PARITY != 0) ? S_PARITY : S_STOP;
            S_PARITY: if (w_sample) w_state_nxt = S_STOP;
            S_STOP:   if (w_sample && w_last_bit) w_state_nxt = S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sample   = 1'b0;
        w_last_bit = 1'b0;
        case (r_state)
            S_START:  w_sample = (r_cnt == C_H_LAST);
            S_DATA: begin
                w_sample   = (r_cnt == C_P_LAST);
                w_last_bit = (r_nb == C_DB_LAST);
            end
            S_PARITY: begin
                w_sample   = (r_cnt == C_P_LAST);
                w_last_bit = 1'b1;
            end
            S_STOP: begin
                w_sample   = (r_cnt == C_P_LAST);
                w_last_bit = (r_nb == C_SB_LAST);
            end
            default: ;
        endcase
    end

    assign w_state_chg   = (w_state_nxt != r_state);
    assign w_start_entry = (r_state == S_IDLE) && (w_state_nxt == S_START);
    assign w_frame_end   = (r_state == S_STOP) && w_sample && w_last_bit;
    assign w_ferr_final  = r_ferr | ~r_rx_s;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_cnt    <= '0;
            r_nb     <= '0;
            r_shift  <= '0;
            r_armed  <= 1'b1;
            r_ferr   <= 1'b0;
            r_perr   <= 1'b0;
            r_commit <= 1'b0;
        end else begin
            if (r_state == S_IDLE || w_state_chg || w_sample)
                r_cnt <= '0;
            else
                r_cnt <= r_cnt + 1'b1;

            if (w_sample && (r_state == S_DATA || r_state == S_STOP))
                r_nb <= w_last_bit ? 4'd0 : r_nb + 4'd1;

            if (w_sample && r_state == S_DATA)
                r_shift <= {r_rx_s, r_shift[C_DATA_BITS-1:1]};

            if (w_start_entry) begin
                r_ferr <= 1'b0;
                r_perr <= 1'b0;
            end else begin
                if (w_sample && r_state == S_PARITY)
                    r_perr <= ((^r_shift) ^ r_rx_s) != C_PAR_REF;
                if (w_sample && r_state == S_STOP && !r_rx_s)
                    r_ferr <= 1'b1;
            end

            // a frame that ends on a low line must see the line high again before re-arming
            if (w_frame_end && w_ferr_final)
                r_armed <= 1'b0;
            else if (r_state == S_IDLE && r_rx_s)
                r_armed <= 1'b1;

            r_commit <= w_frame_end;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_data        <= '0;
            r_ready       <= 1'b0;
            r_err_frame   <= 1'b0;
            r_err_parity  <= 1'b0;
            r_err_overrun <= 1'b0;
        end else if (r_commit) begin
            r_data       <= r_shift;
            r_ready      <= 1'b1;
            r_err_frame  <= r_ferr;
            r_err_parity <= r_perr;
            if (r_ready && !read)
                r_err_overrun <= 1'b1;
            else if (r_ready && read)
                r_err_overrun <= 1'b0;
        end else if (r_ready && read) begin
            r_ready       <= 1'b0;
            r_err_overrun <= 1'b0;
        end
    end

    assign data        = r_data;
    assign ready       = r_ready;
    assign err_frame   = r_err_frame;
    assign err_parity  = r_err_parity;
    assign err_overrun = r_err_overrun;
    assign busy        = r_busy;

endmodule

// File: tb/tb_uart_rx_frame.sv
// tb/tb_uart_rx_frame.sv - self-checking bench for uart_rx_frame over three configurations
module tb_uart_rx_frame;

    localparam int N = 3;

    int P_A [N] = '{100, 16, 20};
    int W_A [N] = '{8, 8, 9};
    int PM_A[N] = '{0, 2, 1};
    int NS_A[N] = '{1, 1, 2};

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0] rstb_v;
    logic [N-1:0] rx_v;
    logic [N-1:0] rd_v;
    wire  [N-1:0] rdy_v, fe_v, pe_v, ovr_v, busy_v;
    wire  [7:0]   d0, d1;
    wire  [8:0]   d2;

    uart_rx_frame #(.C_CLK_FRQ(100000000), .C_TRX_RATE(1000000), .C_DATA_BITS(8),
                    .C_PARITY(0), .C_STOP_BITS(1)) u0 (
        .clk(clk), .rstb(rstb_v[0]), .rx(rx_v[0]), .read(rd_v[0]), .data(d0),
        .ready(rdy_v[0]), .err_frame(fe_v[0]), .err_parity(pe_v[0]),
        .err_overrun(ovr_v[0]), .busy(busy_v[0]));

    uart_rx_frame #(.C_CLK_FRQ(16000000), .C_TRX_RATE(1000000), .C_DATA_BITS(8),
                    .C_PARITY(2), .C_STOP_BITS(1)) u1 (
        .clk(clk), .rstb(rstb_v[1]), .rx(rx_v[1]), .read(rd_v[1]), .data(d1),
        .ready(rdy_v[1]), .err_frame(fe_v[1]), .err_parity(pe_v[1]),
        .err_overrun(ovr_v[1]), .busy(busy_v[1]));

    uart_rx_frame #(.C_CLK_FRQ(20000000), .C_TRX_RATE(1000000), .C_DATA_BITS(9),
                    .C_PARITY(1), .C_STOP_BITS(2)) u2 (
        .clk(clk), .rstb(rstb_v[2]), .rx(rx_v[2]), .read(rd_v[2]), .data(d2),
        .ready(rdy_v[2]), .err_frame(fe_v[2]), .err_parity(pe_v[2]),
        .err_overrun(ovr_v[2]), .busy(busy_v[2]));

    int n_chk = 0;
    int n_bad = 0;

    int           edge_cnt;
    int           first_rdy[N];
    int           rises[N];
    bit           busy_seen[N];
    logic [N-1:0] prev_rdy;

    logic [8:0] m_data[N];
    bit         m_rdy[N], m_fe[N], m_pe[N], m_ovr[N];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [8:0] get_data(input int k);
        case (k)
            0:       return {1'b0, d0};
            1:       return {1'b0, d1};
            default: return d2;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        edge_cnt++;
        for (int k = 0; k < N; k++) begin
            if (rdy_v[k] && !prev_rdy[k]) begin
                rises[k]++;
                if (first_rdy[k] < 0) first_rdy[k] = edge_cnt;
            end
            if (busy_v[k]) busy_seen[k] = 1'b1;
        end
        prev_rdy = rdy_v;
    endtask

    task automatic idle(input int k, input int n);
        rx_v[k] = 1'b1;
        repeat (n) tick();
    endtask

    task automatic rd(input int k);
        rd_v[k] = 1'b1;
        tick();
        rd_v[k] = 1'b0;
        if (m_rdy[k]) begin
            m_rdy[k] = 1'b0;
            m_ovr[k] = 1'b0;
        end
    endtask

    task automatic check(input int k, input string tag);
        chk({tag, ".rdy"},  rdy_v[k],    m_rdy[k]);
        chk({tag, ".data"}, get_data(k), m_data[k]);
        chk({tag, ".fe"},   fe_v[k],     m_fe[k]);
        chk({tag, ".pe"},   pe_v[k],     m_pe[k]);
        chk({tag, ".ovr"},  ovr_v[k],    m_ovr[k]);
        chk({tag, ".busy"}, busy_v[k],   1'b0);
    endtask

    task automatic model_reset(input int k);
        m_data[k] = '0;
        m_rdy[k]  = 1'b0;
        m_fe[k]   = 1'b0;
        m_pe[k]   = 1'b0;
        m_ovr[k]  = 1'b0;
    endtask

    // Serialises one frame on line k; rd_edge > 0 pulses read so it is sampled at that edge
    task automatic send(input int k, input logic [8:0] d, input bit pflip, input bit sbad,
                        input int rd_edge);
        logic [15:0] b;
        logic [8:0]  dm;
        int          p, w, npar, n, pos;
        bit          pbit, fe, rd_hit;
        p    = P_A[k];
        w    = W_A[k];
        npar = (PM_A[k] != 0) ? 1 : 0;
        dm   = d & 9'((1 << w) - 1);
        b    = '1;
        b[0] = 1'b0;
        for (int j = 0; j < w; j++) b[1 + j] = dm[j];
        pbit = 1'b0;
        if (npar == 1) begin
            pbit = ($countones(dm) % 2 == 1);
            if (PM_A[k] == 1) pbit = ~pbit;
            pbit = pbit ^ pflip;
            b[1 + w] = pbit;
        end
        pos = 1 + w + npar;
        fe  = 1'b0;
        for (int s = 0; s < NS_A[k]; s++) begin
            b[pos + s] = !(sbad && s == 0);
            if (!b[pos + s]) fe = 1'b1;
        end
        n = pos + NS_A[k];

        edge_cnt = 0;
        for (int kk = 0; kk < N; kk++) first_rdy[kk] = -1;
        for (int c = 0; c < n * p; c++) begin
            rx_v[k] = b[c / p];
            tick();
            if (rd_edge > 0) begin
                if (edge_cnt == rd_edge - 1) rd_v[k] = 1'b1;
                else if (edge_cnt == rd_edge) rd_v[k] = 1'b0;
            end
        end

        rd_hit = (rd_edge > 0);
        if (m_rdy[k]) m_ovr[k] = !rd_hit;
        m_rdy[k]  = 1'b1;
        m_data[k] = dm;
        m_fe[k]   = fe;
        m_pe[k]   = (npar == 1) &&
                    (($countones(dm) + int'(pbit)) % 2 != ((PM_A[k] == 1) ? 1 : 0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time exceeded");
        $fatal(1);
    end

    initial begin
        int p, gap, nfr;
        bit pf, sb;
        rstb_v   = '0;
        rx_v     = '1;
        rd_v     = '0;
        prev_rdy = '0;
        edge_cnt = 0;
        for (int k = 0; k < N; k++) begin
            model_reset(k);
            first_rdy[k] = -1;
            rises[k]     = 0;
            busy_seen[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) check(k, $sformatf("rst%0d", k));
        rstb_v = '1;
        idle(0, 10);

        send(0, 9'h0A5, 0, 0, 0);
        chk("t1.latency", first_rdy[0], 954);
        check(0, "t1");
        rd(0);
        check(0, "t1.read");

        send(1, 9'h003, 1, 0, 0);
        check(1, "t2.bad_par");
        rd(1);
        idle(1, 5);
        send(1, 9'h003, 0, 0, 0);
        check(1, "t2.good_par");
        rd(1);

        rises[0] = 0;
        send(0, 9'h05A, 0, 1, 0);
        busy_seen[0] = 1'b0;
        rx_v[0] = 1'b0;
        repeat (3000) tick();
        chk("t3.commits", rises[0], 1);
        chk("t3.busy_low", busy_seen[0], 0);
        check(0, "t3");
        rd(0);
        idle(0, 20);
        send(0, 9'h03C, 0, 0, 0);
        check(0, "t3.next");
        rd(0);

        send(0, 9'h011, 0, 0, 0);
        send(0, 9'h022, 0, 0, 0);
        check(0, "t4.ovr");
        rd(0);
        check(0, "t4.read");
        send(0, 9'h044, 0, 0, 0);
        send(0, 9'h055, 0, 0, 954);
        check(0, "t4.sim_read");
        rd(0);

        busy_seen[0] = 1'b0;
        rx_v[0] = 1'b0;
        repeat (20) tick();
        idle(0, 100);
        chk("t5.busy_pulse", busy_seen[0], 1);
        check(0, "t5");

        send(2, 9'h0F3, 0, 0, 0);
        send(2, 9'h10C, 1, 0, 0);
        check(2, "t6.pre");
        rx_v[2] = 1'b0;
        repeat (P_A[2]) tick();
        for (int j = 0; j < 3; j++) begin
            rx_v[2] = j[0];
            repeat (P_A[2]) tick();
        end
        chk("t6.busy_mid", busy_v[2], 1);
        rstb_v[2] = 1'b0;
        #1;
        model_reset(2);
        check(2, "t6.async");
        rx_v[2] = 1'b1;
        tick();
        check(2, "t6.held");
        rstb_v[2] = 1'b1;
        idle(2, 10);
        send(2, 9'h1A5, 0, 0, 0);
        check(2, "t6.after");
        rd(2);

        for (int k = 0; k < N; k++) begin
            p   = P_A[k];
            nfr = (k == 0) ? 4 : 30;
            idle(k, 5);
            for (int f = 0; f < nfr; f++) begin
                pf = (PM_A[k] != 0) && ($urandom_range(0, 3) == 0);
                sb = ($urandom_range(0, 5) == 0);
                send(k, 9'($urandom), pf, sb, 0);
                check(k, $sformatf("rnd%0d.%0d", k, f));
                if ($urandom_range(0, 1) == 1) rd(k);
                gap = sb ? p : (($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, p));
                idle(k, gap);
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
